// File: rtl/parallel_add_decode.sv
// Sliding-window sum decoder: reconstructs a 32-bit vector whose top two bits
// are known (seed) from thirty 3-bit-window sums r_k = b[32-k]+b[31-k]+b[30-k].
// One bit is recovered per clock, MSB first; inconsistent sums set a sticky error.
module parallel_add_decode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [59:0] sums_i,
  input  logic [1:0]  seed_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] register_out_o,
  output logic        error_o
);

  typedef enum logic [0:0] {StIdle, StDecode} state_e;

  state_e      state_q, state_d;
  logic [59:0] sums_q, sums_d;
  logic [31:0] reg_q, reg_d;
  logic [4:0]  k_q, k_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic [4:0]  idx;
  logic [1:0]  r_k;
  logic        b_hi, b_lo;
  logic [3:0]  v;
  logic        v_ok;

  // Datapath for step k: target bit is b[30-k], neighbours are the two bits above it.
  // The difference is taken modulo 16, so negative results fall outside {0,1}.
  always_comb begin
    idx  = 5'd30 - k_q;
    r_k  = sums_q[{idx, 1'b0} +: 2];
    b_hi = reg_q[idx + 5'd2];
    b_lo = reg_q[idx + 5'd1];
    v    = {2'b00, r_k} - {3'b000, b_hi} - {3'b000, b_lo};
    v_ok = (v == 4'd0) || (v == 4'd1);
  end

  // Next-state and register updates for the two-state decode sequencer.
  always_comb begin
    state_d = state_q;
    sums_d  = sums_q;
    reg_d   = reg_q;
    k_d     = k_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = error_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          sums_d  = sums_i;
          reg_d   = {seed_i, 30'd0};
          error_d = 1'b0;
          k_d     = 5'd1;
          busy_d  = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        // An inconsistent sum writes 0 but decoding carries on to the end.
        reg_d[idx] = v_ok ? v[0] : 1'b0;
        if (!v_ok) begin
          error_d = 1'b1;
        end
        if (k_q == 5'd30) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          k_d = k_q + 5'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sums_q  <= 60'd0;
      reg_q   <= 32'd0;
      k_q     <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sums_q  <= sums_d;
      reg_q   <= reg_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign register_out_o = reg_q;
  assign error_o        = error_q;

endmodule
